alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: none; opcode values are the ALU_OP_* macros from defines.vh: ADD=0000, SLR=0001, SUB/BEQ=0010, BNE=0011, AND=0100, OR=0101, XOR=0110, SLL=0111, SAR=1000, BLTU=1010, BGEU=1011.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  instruction and operands presented.
REQ-005 in_ready  output  1  stage can accept.
REQ-006 instr  input  32  RV32 instruction word.
REQ-007 pc  input  32  instruction address.
REQ-008 rs1_data, rs2_data  input  32 each  register operands.
REQ-009 flush  input  1  discard held entry.
REQ-010 out_valid  output  1  registered entry valid toward ALU.
REQ-011 out_ready  input  1  ALU side consumes.
REQ-012 alu_a, alu_b  output  32 each  ALU operands A, B.
REQ-013 alu_op  output  4  ALU opcode.
REQ-014 rd  output  5; wb_en  output  1; is_branch  output  1; illegal  output  1.

Function
REQ-015 Single register stage; in_ready SHALL equal !out_valid | out_ready (combinational).
REQ-016 Capture on edge when in_valid & in_ready & !flush; out_valid<=1; all outputs from decode of instr, one-cycle latency.
REQ-017 out_valid & out_ready & !(in_valid & in_ready) SHALL clear out_valid next edge; held outputs SHALL stay stable while out_valid & !out_ready.
REQ-018 flush SHALL clear out_valid next edge with priority over capture and hold; in_ready unaffected by flush.
REQ-019 OP (opcode 0110011): A=rs1, B=rs2; f3/f7: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 100 XOR, 101/0000000 SLR, 101/0100000 SAR, 110 OR, 111 AND.
REQ-020 OP-IMM (0010011): A=rs1, B=sign-extended instr[31:20]; ADDI, XORI, ORI, ANDI, SLLI, SRLI, SRAI (shift B[31:5]=0, f7 selects SLR/SAR).
REQ-021 BRANCH (1100011): A=rs1, B=rs2; f3 000 BEQ, 001 BNE, 110 BLTU, 111 BGEU; is_branch=1, wb_en=0.
REQ-022 rd=instr[11:7]; wb_en=1 for OP/OP-IMM (and LUI/AUIPC when enabled) only when rd!=0.
REQ-023 Illegal (unknown opcode, SLT/SLTU/SLTI/SLTIU, BLT/BGE, bad f7): illegal=1, alu_op=ADD, A=B=0, wb_en=0, is_branch=0; entry still flows through handshake.
REQ-024 Simultaneous drain and capture SHALL keep out_valid=1 with new contents, no bubble.

Reset
REQ-025 rst high SHALL immediately force out_valid=0, alu_a=alu_b=0, alu_op=ADD, rd=0, wb_en=0, is_branch=0, illegal=0.
REQ-026 Reset mid-operation SHALL drop the held entry; first capture allowed on first edge after rst deasserts.

Configuration
REQ-027 Macro ALU_ISSUE_LUI_AUIPC_EN defined: LUI (0110111) A=0, AUIPC (0010111) A=pc, both B={instr[31:12],12'b0}, alu_op=ADD.
REQ-028 Macro undefined: LUI/AUIPC decode illegal per REQ-023.

Verification
REQ-029 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op=0000, A=5, B=7, rd=3, wb_en=1.
REQ-030 srai x5,x6,4 (0x40435293), rs1=0x80000000 -> op=1000, B=4, wb_en=1, illegal=0.
REQ-031 bgeu x1,x2 (f3=111), out_ready=0 for 3 cycles -> op=1011, is_branch=1, wb_en=0, outputs stable, in_ready=0 until out_ready=1.
REQ-032 slt (f3=010, opcode 0110011) -> illegal=1, op=0000, A=B=0, wb_en=0.
REQ-033 Valid entry held, flush=1 with in_valid=1 same cycle -> out_valid=0 next edge, new instr not captured.
REQ-034 lui x1,0x12345 -> with macro: A=0, B=0x12345000, wb_en=1; without: illegal=1; rst pulse mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: RV32 decode/issue register stage feeding the ALU; `define ALU_ISSUE_LUI_AUIPC_EN adds LUI/AUIPC decode
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  rd,
    output logic        wb_en,
    output logic        is_branch,
    output logic        illegal
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLR  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SAR  = 4'b1000;
    localparam logic [3:0] OP_BLTU = 4'b1010;
    localparam logic [3:0] OP_BGEU = 4'b1011;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_f;
    logic [31:0] imm_i;
    logic arith, f7z, f7a, f7_chk, f7_ok;
    logic d_ill, d_wb, d_br;
    logic [3:0] d_op;
    logic [31:0] d_a, d_b;
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign rd_f = instr[11:7];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign arith = instr[5];
    assign f7z = f7 == 7'b0000000;
    assign f7a = f7 == 7'b0100000;
    // OP checks funct7 on every funct3; OP-IMM only on shifts, where funct7 is part of the encoding
    assign f7_chk = arith || f3 == 3'd1 || f3 == 3'd5;
    assign f7_ok = f7z || (f7a && (f3 == 3'd5 || (f3 == 3'd0 && arith)));
    assign in_ready = !out_valid || out_ready;
`ifndef ALU_ISSUE_LUI_AUIPC_EN
    logic unused;
    assign unused = ^{pc, instr[19:15]};
`endif
    always_comb begin
        d_op = OP_ADD;
        d_a = rs1_data;
        d_b = rs2_data;
        d_wb = 1'b0;
        d_br = 1'b0;
        d_ill = 1'b0;
        case (instr[6:0])
            7'b0110011, 7'b0010011: begin
                d_op = f3 == 3'd0 ? (arith && f7a ? OP_SUB : OP_ADD) :
                       f3 == 3'd1 ? OP_SLL :
                       f3 == 3'd4 ? OP_XOR :
                       f3 == 3'd5 ? (f7a ? OP_SAR : OP_SLR) :
                       f3 == 3'd6 ? OP_OR : OP_AND;
                d_ill = f3[2:1] == 2'b01 || (f7_chk && !f7_ok);
                d_b = arith ? rs2_data : (f3[1:0] == 2'b01 ? {27'd0, instr[24:20]} : imm_i);
                d_wb = rd_f != 5'd0;
            end
            7'b1100011: begin
                d_op = f3 == 3'd0 ? OP_SUB : f3 == 3'd1 ? OP_BNE : f3 == 3'd6 ? OP_BLTU : OP_BGEU;
                d_ill = f3[2] ^ f3[1];
                d_br = 1'b1;
            end
`ifdef ALU_ISSUE_LUI_AUIPC_EN
            7'b0110111, 7'b0010111: begin
                d_a = instr[5] ? 32'd0 : pc;
                d_b = {instr[31:12], 12'd0};
                d_wb = rd_f != 5'd0;
            end
`endif
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_op = OP_ADD;
            d_a = 32'd0;
            d_b = 32'd0;
            d_wb = 1'b0;
            d_br = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_a <= 32'd0;
            alu_b <= 32'd0;
            alu_op <= OP_ADD;
            rd <= 5'd0;
            wb_en <= 1'b0;
            is_branch <= 1'b0;
            illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            alu_a <= d_a;
            alu_b <= d_b;
            alu_op <= d_op;
            rd <= rd_f;
            wb_en <= d_wb;
            is_branch <= d_br;
            illegal <= d_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
